// File: rtl/diff_scan_pkg.sv
// diff_scan_pkg
// Shared types and constants for the differing-bit scan unit.
//   state_t        : scan controller states (IDLE, SCAN, DONE)
//   DIFF_LSB_FIRST : mode value selecting the lowest differing bit
//   DIFF_MSB_FIRST : mode value selecting the highest differing bit
package diff_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic DIFF_LSB_FIRST = 1'b0;
  localparam logic DIFF_MSB_FIRST = 1'b1;

endpackage

// File: rtl/diff_chunk_enc.sv
// diff_chunk_enc
// Combinational CHUNK-bit priority encoder with selectable direction.
// Ports:
//   bits : chunk of the latched a^b vector
//   dir  : DIFF_LSB_FIRST picks the lowest set bit, DIFF_MSB_FIRST the highest
//   hit  : at least one bit of the chunk is set
//   idx  : bit position of the selected set bit inside the chunk
module diff_chunk_enc #(
  parameter int CHUNK  = 8,
  parameter int LIDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
  input  logic [CHUNK-1:0]  bits,
  input  logic              dir,
  output logic              hit,
  output logic [LIDX_W-1:0] idx
);
  import diff_scan_pkg::*;

  // The last matching assignment in each loop wins, so the loop order
  // decides which end of the chunk has priority.
  always_comb begin
    hit = |bits;
    idx = '0;
    if (dir == DIFF_LSB_FIRST) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (bits[i]) idx = LIDX_W'(i);
      end
    end else begin
      for (int i = 0; i < CHUNK; i++) begin
        if (bits[i]) idx = LIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/diff_scan_unit.sv
// diff_scan_unit
// Multi-cycle differing-bit locator: finds the first bit where a and b
// differ, examining CHUNK bits per cycle, LSB-first or MSB-first.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready only while idle)
//   a, b, mode          : operands and scan direction, sampled at accept
//   out_valid, out_ready: result handshake, result held until accepted
//   diff_idx            : differing-bit index, WIDTH when a == b
//   no_diff             : set when a == b
//   diff_cnt            : Hamming distance of a and b (DIFF_SCAN_POPCNT_EN only)
// Build option:
//   DIFF_SCAN_POPCNT_EN : adds diff_cnt, scans every chunk (no early exit)
module diff_scan_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] diff_idx,
  output logic             no_diff
`ifdef DIFF_SCAN_POPCNT_EN
  ,
  output logic [IDX_W-1:0] diff_cnt
`endif
);
  import diff_scan_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LIDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  state_t             state;
  logic [WIDTH-1:0]   x_q;
  logic               mode_q;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   chunk_base;
  logic [CHUNK-1:0]   chunk_bits;
  logic               hit;
  logic [LIDX_W-1:0]  local_idx;
  logic [IDX_W-1:0]   abs_idx;
`ifdef DIFF_SCAN_POPCNT_EN
  logic               found;
  logic [IDX_W-1:0]   chunk_pop;
`endif

  assign in_ready = (state == IDLE);

  // Chunk k sits at bit offset k*CHUNK from the LSB end, or counts down
  // from the MSB end in MSB-first mode; the offset doubles as the base of
  // the absolute index since the encoder reports physical bit positions.
  always_comb begin
    chunk_base = '0;
    if (mode_q == DIFF_MSB_FIRST) begin
      chunk_base = IDX_W'(WIDTH - (int'(cnt) + 1) * CHUNK);
    end else begin
      chunk_base = IDX_W'(int'(cnt) * CHUNK);
    end
    chunk_bits = CHUNK'(x_q >> chunk_base);
    abs_idx    = chunk_base + IDX_W'(local_idx);
  end

`ifdef DIFF_SCAN_POPCNT_EN
  assign chunk_pop = IDX_W'($countones(chunk_bits));
`endif

  diff_chunk_enc #(
    .CHUNK  (CHUNK),
    .LIDX_W (LIDX_W)
  ) u_enc (
    .bits (chunk_bits),
    .dir  (mode_q),
    .hit  (hit),
    .idx  (local_idx)
  );

  // Controller: accept, scan one chunk per cycle, hold the result until
  // the consumer takes it. The counter stops at the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      diff_idx  <= '0;
      no_diff   <= 1'b0;
      cnt       <= '0;
      x_q       <= '0;
      mode_q    <= 1'b0;
`ifdef DIFF_SCAN_POPCNT_EN
      found     <= 1'b0;
      diff_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q    <= a ^ b;
            mode_q <= mode;
            cnt    <= '0;
            state  <= SCAN;
`ifdef DIFF_SCAN_POPCNT_EN
            found    <= 1'b0;
            diff_cnt <= '0;
`endif
          end
        end
        SCAN: begin
`ifdef DIFF_SCAN_POPCNT_EN
          // Every chunk is visited; the first hit in scan order is kept.
          diff_cnt <= diff_cnt + chunk_pop;
          if (hit && !found) begin
            diff_idx <= abs_idx;
            no_diff  <= 1'b0;
            found    <= 1'b1;
          end
          if (cnt == LAST_CHUNK) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (!found && !hit) begin
              diff_idx <= IDX_W'(WIDTH);
              no_diff  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          if (hit) begin
            diff_idx  <= abs_idx;
            no_diff   <= 1'b0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (cnt == LAST_CHUNK) begin
            diff_idx  <= IDX_W'(WIDTH);
            no_diff   <= 1'b1;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_scan_unit.sv
// tb_diff_scan_unit
// Self-checking bench for diff_scan_unit (WIDTH=32, CHUNK=8): directed
// vector table, backpressure and reset corner cases, and randomized
// requests compared against a bit-walking reference model.
// Honours DIFF_SCAN_POPCNT_EN when defined.
module tb_diff_scan_unit;
  import diff_scan_pkg::*;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] diff_idx;
  logic             no_diff;
`ifdef DIFF_SCAN_POPCNT_EN
  logic [IDX_W-1:0] diff_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    int               exp_idx;
    int               exp_nd;
    int               exp_lat;
    string            name;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  diff_scan_unit #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_idx  (diff_idx),
    .no_diff   (no_diff)
`ifdef DIFF_SCAN_POPCNT_EN
    ,
    .diff_cnt  (diff_cnt)
`endif
  );

  // Single comparison point: every check goes through here.
  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: walk the bits of a^b in scan order, stop at the first set bit.
  function automatic void model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic m, output int idx, output int nd,
                                output int lat, output int cnt);
    logic [WIDTH-1:0] x;
    int step;
    x    = av ^ bv;
    idx  = WIDTH;
    nd   = 1;
    step = WIDTH;
    for (int s = 0; s < WIDTH; s++) begin
      int p;
      p = (m == DIFF_MSB_FIRST) ? (WIDTH - 1 - s) : s;
      if (x[p] && nd == 1) begin
        idx  = p;
        nd   = 0;
        step = s;
      end
    end
    lat = (nd == 1) ? NCHUNK : (step / CHUNK + 1);
    cnt = $countones(x);
  endfunction

  function automatic int scan_latency(input int early);
`ifdef DIFF_SCAN_POPCNT_EN
    return NCHUNK;
`else
    return early;
`endif
  endfunction

  // Present one request, scramble the inputs after accept, and count the
  // edges until out_valid (bounded).
  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic m, output int lat);
    check_output("in_ready before accept", int'(in_ready), 1);
    a        = av;
    b        = bv;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    mode     = 1'($urandom);
    lat      = 0;
    while (!out_valid && lat < 3 * NCHUNK) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input int exp_idx, input int exp_nd,
                              input int exp_lat, input int exp_cnt, input int lat);
    check_output($sformatf("%s out_valid", nm), int'(out_valid), 1);
    check_output($sformatf("%s latency", nm), lat, exp_lat);
    check_output($sformatf("%s diff_idx", nm), int'(diff_idx), exp_idx);
    check_output($sformatf("%s no_diff", nm), int'(no_diff), exp_nd);
`ifdef DIFF_SCAN_POPCNT_EN
    check_output($sformatf("%s diff_cnt", nm), int'(diff_cnt), exp_cnt);
`else
    if (exp_cnt < 0) $display("[TB] unexpected negative popcount");
`endif
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("out_valid after handshake", int'(out_valid), 0);
    check_output("in_ready after handshake", int'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int m_idx, m_nd, m_lat, m_cnt;
    logic [WIDTH-1:0] ra, rb, one;
    logic rm;

    vecs[0] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 0,  0, 1, "lsb bit0"};
    vecs[1] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 31, 0, 4, "lsb bit31"};
    vecs[2] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 31, 0, 1, "msb bit31"};
    vecs[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32, 1, 4, "equal lsb"};
    vecs[4] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32, 1, 4, "equal msb"};
    vecs[5] = '{32'h0001_0100, 32'h0000_0000, 1'b1, 16, 0, 2, "two bits msb"};
    vecs[6] = '{32'h0001_0100, 32'h0000_0000, 1'b0, 8,  0, 2, "two bits lsb"};
    vecs[7] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 0,  0, 1, "all differ lsb"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset out_valid", int'(out_valid), 0);
    check_output("reset in_ready", int'(in_ready), 1);
    check_output("reset diff_idx", int'(diff_idx), 0);
    check_output("reset no_diff", int'(no_diff), 0);
`ifdef DIFF_SCAN_POPCNT_EN
    check_output("reset diff_cnt", int'(diff_cnt), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors from the table.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].mode, lat);
      check_result(vecs[i].name, vecs[i].exp_idx, vecs[i].exp_nd,
                   scan_latency(vecs[i].exp_lat), $countones(vecs[i].a ^ vecs[i].b), lat);
      handshake();
    end

    // Backpressure: result must hold and new requests must be ignored.
    apply_stimulus(32'h0000_0001, 32'h0000_0000, DIFF_LSB_FIRST, lat);
    check_result("backpressure", 0, 0, scan_latency(1), 1, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = 32'h0000_0000;
      mode     = 1'b1;
      @(posedge clk);
      #1;
      check_output("bp out_valid held", int'(out_valid), 1);
      check_output("bp diff_idx held", int'(diff_idx), 0);
      check_output("bp no_diff held", int'(no_diff), 0);
      check_output("bp in_ready low", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    handshake();
    @(posedge clk);
    #1;
    check_output("bp pulse ignored", int'(out_valid), 0);
    check_output("bp idle after release", int'(in_ready), 1);

    // Reset in the middle of a scan discards the request.
    a        = 32'hDEAD_BEEF;
    b        = 32'hDEAD_BEEF;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid-scan rst out_valid", int'(out_valid), 0);
    check_output("mid-scan rst in_ready", int'(in_ready), 1);
    check_output("mid-scan rst diff_idx", int'(diff_idx), 0);
    check_output("mid-scan rst no_diff", int'(no_diff), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2 * NCHUNK) @(posedge clk);
    #1;
    check_output("discarded result stays invisible", int'(out_valid), 0);

    // Recovery after reset.
    apply_stimulus(vecs[5].a, vecs[5].b, vecs[5].mode, lat);
    check_result("after reset", 16, 0, scan_latency(2), 2, lat);
    handshake();

    // Randomized requests against the reference model.
    one = 32'h0000_0001;
    for (int n = 0; n < 150; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (one << $urandom_range(0, WIDTH - 1));
        2:       rb = ra ^ ($urandom & $urandom & $urandom);
        default: rb = $urandom;
      endcase
      rm = 1'($urandom);
      model(ra, rb, rm, m_idx, m_nd, m_lat, m_cnt);
      apply_stimulus(ra, rb, rm, lat);
      check_result($sformatf("rand %0d", n), m_idx, m_nd, scan_latency(m_lat), m_cnt, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        check_output("rand hold diff_idx", int'(diff_idx), m_idx);
      end
      handshake();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
